// File: rtl/reg_wb_unit_if.sv
// Bus bundle for reg_wb_unit: two write-request sources, register-file write port,
// hazard/forwarding probes and the sticky error flag.
interface reg_wb_unit_if #(
  parameter int unsigned pw = 3
);
  logic          mem_valid;
  logic [pw-1:0] mem_addr;
  logic [7:0]    mem_data;
  logic          mem_ready;
  logic          alu_valid;
  logic [pw-1:0] alu_addr;
  logic [7:0]    alu_data;
  logic          alu_ready;
  logic          flush;
  logic          wr_en;
  logic [pw-1:0] wr_addr;
  logic [7:0]    dat_in;
  logic [pw-1:0] chk_addrA;
  logic [pw-1:0] chk_addrB;
  logic          hazA;
  logic          hazB;
  logic [7:0]    fwdA;
  logic [7:0]    fwdB;
  logic          err;

  modport master (
    output mem_valid, mem_addr, mem_data,
    output alu_valid, alu_addr, alu_data,
    output flush, chk_addrA, chk_addrB,
    input  mem_ready, alu_ready,
    input  wr_en, wr_addr, dat_in,
    input  hazA, hazB, fwdA, fwdB, err
  );

  modport slave (
    input  mem_valid, mem_addr, mem_data,
    input  alu_valid, alu_addr, alu_data,
    input  flush, chk_addrA, chk_addrB,
    output mem_ready, alu_ready,
    output wr_en, wr_addr, dat_in,
    output hazA, hazB, fwdA, fwdB, err
  );
endinterface

// File: rtl/reg_wb_unit.sv
// Register write-back queue: merges load and ALU results into an in-order FIFO,
// drains one entry per cycle to the register file, and forwards pending data.
module reg_wb_unit #(
  parameter int unsigned pw    = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_wb_unit_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned DW = 8;

  typedef struct packed {
    logic [pw-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t        slot_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_en_q, wr_en_d;
  logic [pw-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] dat_in_q, dat_in_d;
  logic          err_q, err_d;

  logic          mem_ready_c;
  logic          alu_ready_c;
  logic          mem_push_c;
  logic          alu_push_c;
  logic          pop_c;
  logic [AW-1:0] alu_slot_c;
  logic          haz_a_c, haz_b_c;
  logic [DW-1:0] fwd_a_c, fwd_b_c;

  // Readiness depends only on occupancy; the ALU also needs room behind a same-cycle load.
  always_comb begin
    mem_ready_c = (count_q < CW'(DEPTH));
    alu_ready_c = (count_q <= CW'(DEPTH - 2)) || (mem_ready_c && !bus.mem_valid);
    mem_push_c  = bus.mem_valid && mem_ready_c && !bus.flush;
    alu_push_c  = bus.alu_valid && alu_ready_c && !bus.flush;
    pop_c       = (count_q != '0) && !bus.flush;
    alu_slot_c  = wr_ptr_q + AW'(mem_push_c);
  end

  // Next-state for pointers, occupancy, output stage and sticky error.
  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    dat_in_d  = dat_in_q;
    err_d     = err_q
              | (bus.mem_valid & ~mem_ready_c)
              | (bus.alu_valid & ~alu_ready_c);

    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_c) begin
        wr_en_d   = 1'b1;
        wr_addr_d = slot_q[rd_ptr_q].addr;
        dat_in_d  = slot_q[rd_ptr_q].data;
        rd_ptr_d  = rd_ptr_q + AW'(1);
      end
      wr_ptr_d = wr_ptr_q + AW'(mem_push_c) + AW'(alu_push_c);
      count_d  = count_q + CW'(mem_push_c) + CW'(alu_push_c) - CW'(pop_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      dat_in_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      dat_in_q  <= dat_in_d;
      err_q     <= err_d;
    end
  end

  // Entry storage needs no reset: only slots covered by count_q are ever read.
  always_ff @(posedge clk) begin
    if (mem_push_c) slot_q[wr_ptr_q]   <= '{addr: bus.mem_addr, data: bus.mem_data};
    if (alu_push_c) slot_q[alu_slot_c] <= '{addr: bus.alu_addr, data: bus.alu_data};
  end

  // Probe scan runs oldest to youngest so the youngest match wins.
  always_comb begin
    haz_a_c = 1'b0;
    fwd_a_c = '0;
    haz_b_c = 1'b0;
    fwd_b_c = '0;
    if (wr_en_q && (wr_addr_q == bus.chk_addrA)) begin
      haz_a_c = 1'b1;
      fwd_a_c = dat_in_q;
    end
    if (wr_en_q && (wr_addr_q == bus.chk_addrB)) begin
      haz_b_c = 1'b1;
      fwd_b_c = dat_in_q;
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q) begin
        if (slot_q[rd_ptr_q + AW'(k)].addr == bus.chk_addrA) begin
          haz_a_c = 1'b1;
          fwd_a_c = slot_q[rd_ptr_q + AW'(k)].data;
        end
        if (slot_q[rd_ptr_q + AW'(k)].addr == bus.chk_addrB) begin
          haz_b_c = 1'b1;
          fwd_b_c = slot_q[rd_ptr_q + AW'(k)].data;
        end
      end
    end
  end

  assign bus.mem_ready = mem_ready_c;
  assign bus.alu_ready = alu_ready_c;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.dat_in    = dat_in_q;
  assign bus.err       = err_q;
  assign bus.hazA      = haz_a_c;
  assign bus.hazB      = haz_b_c;
  assign bus.fwdA      = fwd_a_c;
  assign bus.fwdB      = fwd_b_c;

endmodule

// File: tb/tb_reg_wb_unit.sv
// Self-checking bench for reg_wb_unit: directed scenarios plus a random phase,
// all compared against a queue-based model of the write-back behaviour.
module tb_reg_wb_unit;

  localparam int PW    = 3;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  reg_wb_unit_if #(.pw(PW)) bus ();

  reg_wb_unit #(.pw(PW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [PW-1:0] a;
    logic [7:0]    d;
  } ent_t;

  ent_t          q[$];
  logic          out_v;
  logic [PW-1:0] out_a;
  logic [7:0]    out_d;
  logic          m_err;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_mem_rdy();
    return (DEPTH - q.size()) >= 1;
  endfunction

  function automatic logic m_alu_rdy(input logic mv);
    int free;
    free = DEPTH - q.size();
    return (free >= 2) || ((free >= 1) && !mv);
  endfunction

  // Youngest pending write to register c: newest queued entry first, then the output stage.
  function automatic void m_probe(input logic [PW-1:0] c, output logic h, output logic [7:0] f);
    h = 1'b0;
    f = 8'h00;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a == c) begin
        h = 1'b1;
        f = q[i].d;
        return;
      end
    end
    if (out_v && out_a == c) begin
      h = 1'b1;
      f = out_d;
    end
  endfunction

  task automatic m_reset();
    q.delete();
    out_v = 1'b0;
    out_a = '0;
    out_d = 8'h00;
    m_err = 1'b0;
  endtask

  task automatic idle();
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b0;
    bus.flush     = 1'b0;
  endtask

  // One clock: check combinational outputs, advance model, check registered outputs.
  task automatic cycle();
    logic       mr, ar, h;
    logic [7:0] f;
    ent_t       e;
    #1;
    mr = m_mem_rdy();
    ar = m_alu_rdy(bus.mem_valid);
    chk("mem_ready", bus.mem_ready, mr);
    chk("alu_ready", bus.alu_ready, ar);
    m_probe(bus.chk_addrA, h, f);
    chk("hazA", bus.hazA, h);
    chk("fwdA", bus.fwdA, f);
    m_probe(bus.chk_addrB, h, f);
    chk("hazB", bus.hazB, h);
    chk("fwdB", bus.fwdB, f);
    if ((bus.mem_valid && !mr) || (bus.alu_valid && !ar)) m_err = 1'b1;
    if (bus.flush) begin
      q.delete();
      out_v = 1'b0;
    end else begin
      out_v = 1'b0;
      if (q.size() > 0) begin
        e     = q.pop_front();
        out_v = 1'b1;
        out_a = e.a;
        out_d = e.d;
      end
      if (bus.mem_valid && mr) q.push_back(ent_t'{bus.mem_addr, bus.mem_data});
      if (bus.alu_valid && ar) q.push_back(ent_t'{bus.alu_addr, bus.alu_data});
    end
    @(posedge clk);
    #1;
    chk("wr_en", bus.wr_en, out_v);
    chk("wr_addr", bus.wr_addr, out_a);
    chk("dat_in", bus.dat_in, out_d);
    chk("err", bus.err, m_err);
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_wr_en"}, bus.wr_en, 1'b0);
    chk({tag, "_wr_addr"}, bus.wr_addr, 0);
    chk({tag, "_dat_in"}, bus.dat_in, 0);
    chk({tag, "_err"}, bus.err, 1'b0);
    chk({tag, "_mem_ready"}, bus.mem_ready, 1'b1);
    chk({tag, "_alu_ready"}, bus.alu_ready, 1'b1);
    chk({tag, "_hazA"}, bus.hazA, 1'b0);
    chk({tag, "_hazB"}, bus.hazB, 1'b0);
    chk({tag, "_fwdA"}, bus.fwdA, 0);
    chk({tag, "_fwdB"}, bus.fwdB, 0);
  endtask

  // Drive both sources whenever the model says they would be accepted.
  task automatic fill_step(input int i);
    bus.flush     = 1'b0;
    bus.mem_valid = m_mem_rdy();
    bus.mem_addr  = PW'(i);
    bus.mem_data  = 8'($urandom);
    bus.alu_valid = m_alu_rdy(bus.mem_valid);
    bus.alu_addr  = PW'(i + 4);
    bus.alu_data  = 8'($urandom);
    cycle();
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    bus.mem_addr  = '0;
    bus.mem_data  = 8'h00;
    bus.alu_addr  = '0;
    bus.alu_data  = 8'h00;
    bus.chk_addrA = '0;
    bus.chk_addrB = '0;
    m_reset();
    #1 rst_n = 1'b0;
    #1;
    reset_checks("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Single load: one-cycle latency, hazard visible while queued and in output stage.
    bus.chk_addrA = 3'd3;
    bus.chk_addrB = 3'd6;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 3'd3;
    bus.mem_data  = 8'h5A;
    cycle();
    chk("single_queued_hazA", bus.hazA, 1'b1);
    chk("single_queued_fwdA", bus.fwdA, 8'h5A);
    chk("single_queued_wr_en", bus.wr_en, 1'b0);
    idle();
    cycle();
    chk("single_out_wr_en", bus.wr_en, 1'b1);
    chk("single_out_wr_addr", bus.wr_addr, 3'd3);
    chk("single_out_dat_in", bus.dat_in, 8'h5A);
    chk("single_out_hazA", bus.hazA, 1'b1);
    chk("single_out_fwdA", bus.fwdA, 8'h5A);
    cycle();
    chk("single_done_wr_en", bus.wr_en, 1'b0);
    chk("single_done_hazA", bus.hazA, 1'b0);

    // Same-cycle load and ALU result to one register: load first, ALU data forwarded.
    bus.chk_addrA = 3'd2;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 3'd2;
    bus.mem_data  = 8'h11;
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 3'd2;
    bus.alu_data  = 8'h22;
    cycle();
    chk("pair_fwdA_both", bus.fwdA, 8'h22);
    idle();
    cycle();
    chk("pair_first_wr_en", bus.wr_en, 1'b1);
    chk("pair_first_addr", bus.wr_addr, 3'd2);
    chk("pair_first_data", bus.dat_in, 8'h11);
    chk("pair_fwdA_one", bus.fwdA, 8'h22);
    cycle();
    chk("pair_second_wr_en", bus.wr_en, 1'b1);
    chk("pair_second_data", bus.dat_in, 8'h22);
    cycle();
    chk("pair_done_wr_en", bus.wr_en, 1'b0);

    // Continuous ALU stream across pointer wrap.
    for (int i = 0; i < DEPTH + 2; i++) begin
      idle();
      bus.alu_valid = 1'b1;
      bus.alu_addr  = PW'(i);
      bus.alu_data  = 8'(i);
      cycle();
    end
    idle();
    repeat (3) cycle();

    // Two sources back to back: occupancy settles at DEPTH-1 and ALU is held off.
    for (int i = 0; i < 8; i++) fill_step(i);
    chk("fill_alu_ready_low", bus.alu_ready, 1'b0);
    chk("fill_mem_ready_high", bus.mem_ready, 1'b1);
    chk("fill_err_clear", bus.err, 1'b0);

    // Flush with entries pending.
    idle();
    bus.chk_addrA = q[q.size() - 1].a;
    bus.chk_addrB = q[0].a;
    bus.flush     = 1'b1;
    cycle();
    chk("flush_wr_en", bus.wr_en, 1'b0);
    chk("flush_hazA", bus.hazA, 1'b0);
    chk("flush_hazB", bus.hazB, 1'b0);
    chk("flush_alu_ready", bus.alu_ready, 1'b1);
    idle();
    repeat (3) begin
      cycle();
      chk("post_flush_wr_en", bus.wr_en, 1'b0);
    end

    // Handshake violation makes err sticky; async reset mid-queue clears everything.
    for (int i = 0; i < 3; i++) fill_step(i);
    bus.mem_valid = 1'b1;
    bus.alu_valid = 1'b1;
    cycle();
    chk("viol_err_set", bus.err, 1'b1);
    idle();
    cycle();
    chk("viol_err_held", bus.err, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    reset_checks("mid_rst");
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      cycle();
      chk("post_rst_wr_en", bus.wr_en, 1'b0);
    end

    // Random traffic, mostly honouring ready, with occasional flushes.
    for (int n = 0; n < 400; n++) begin
      bus.flush     = ($urandom_range(0, 15) == 0);
      bus.mem_valid = ($urandom_range(0, 1) == 1) && (m_mem_rdy() || $urandom_range(0, 7) == 0);
      bus.mem_addr  = PW'($urandom);
      bus.mem_data  = 8'($urandom);
      bus.alu_valid = ($urandom_range(0, 1) == 1)
                    && (m_alu_rdy(bus.mem_valid) || $urandom_range(0, 7) == 0);
      bus.alu_addr  = PW'($urandom);
      bus.alu_data  = 8'($urandom);
      bus.chk_addrA = PW'($urandom);
      bus.chk_addrB = PW'($urandom);
      cycle();
    end
    idle();
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
